// File: rtl/rx_sample_decimator_pkg.sv
// Shared definitions for the rx sample path: FSM encoding, output sample
// width and the signed 16-bit saturation limits.
package rx_sample_decimator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } rx_state_e;

  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/rx_saturate.sv
// Clips a signed value of parameterized width to the signed 16-bit range
// and reports whether clipping took place.
module rx_saturate
  import rx_sample_decimator_pkg::*;
#(
  parameter int IN_W = 17
) (
  input  logic signed [IN_W-1:0]     din,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       ovf
);

  logic [IN_W-SAMPLE_W:0] top_bits;

  // A value fits in 16 bits only when bit 15 and everything above it are
  // copies of the sign bit; otherwise clip toward the sign.
  always_comb begin
    top_bits = din[IN_W-1:SAMPLE_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    if (!ovf) begin
      dout = din[SAMPLE_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = SAT_MIN;
    end else begin
      dout = SAT_MAX;
    end
  end

endmodule

// File: rtl/rx_sample_decimator.sv
// Box-car decimator for the ADC receive path: sums 2^DECIM_LOG2 valid
// samples, divides by the window size (floor), removes a DC offset,
// saturates to 16 bits and presents the result with a one-cycle trigger.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | receiver disabled; samples ignored, waits for erx_en
// ST_ACCUM | summing valid samples into the window accumulator
// ST_EMIT  | full window sum held; result registered this cycle, and a
//          | valid sample here opens the next window
module rx_sample_decimator
  import rx_sample_decimator_pkg::*;
#(
  parameter int DECIM_LOG2 = 3,
  parameter int IN_WIDTH   = 16
) (
  input  logic                       crx_clk,
  input  logic                       rrx_rst,
  input  logic                       erx_en,
  input  logic signed [IN_WIDTH-1:0] iadc_data,
  input  logic                       iadc_valid,
  input  logic signed [15:0]         idc_offset,
  output logic signed [15:0]         odata_out,
  output logic                       onew_sample_trig,
  output logic                       osat_flag
);

  localparam int ACC_W = IN_WIDTH + DECIM_LOG2;
  // One bit of headroom over the wider of the mean and the offset; for a
  // 16-bit ADC this is the IN_WIDTH+1 subtraction width.
  localparam int SUB_W = ((IN_WIDTH > SAMPLE_W) ? IN_WIDTH : SAMPLE_W) + 1;

  rx_state_e state, state_nxt;

  logic [ACC_W-1:0]          acc, acc_nxt;
  logic [DECIM_LOG2-1:0]     cnt, cnt_nxt;
  logic                      emit;
  logic [ACC_W-1:0]          data_ext;
  logic [IN_WIDTH-1:0]       mean;
  logic signed [SUB_W-1:0]   diff;
  logic signed [SAMPLE_W-1:0] sat_data;
  logic                      sat_ovf;

  // Sign extension of the incoming sample and the offset-corrected mean.
  // Dropping the low DECIM_LOG2 bits of the two's-complement sum is an
  // arithmetic shift, i.e. a floor division by the window size.
  always_comb begin
    data_ext = {{DECIM_LOG2{iadc_data[IN_WIDTH-1]}}, iadc_data};
    mean     = acc[ACC_W-1:DECIM_LOG2];
    diff     = {{(SUB_W-IN_WIDTH){mean[IN_WIDTH-1]}}, mean}
             - {{(SUB_W-SAMPLE_W){idc_offset[SAMPLE_W-1]}}, idc_offset};
  end

  rx_saturate #(
    .IN_W (SUB_W)
  ) u_saturate (
    .din  (diff),
    .dout (sat_data),
    .ovf  (sat_ovf)
  );

  // Next-state, accumulator and counter update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        if (erx_en) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!erx_en) begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else if (iadc_valid) begin
          acc_nxt = acc + data_ext;
          cnt_nxt = cnt + DECIM_LOG2'(1);
          if (cnt == '1) begin
            state_nxt = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        // The result is committed even if the receiver is being disabled.
        emit = 1'b1;
        if (!erx_en) begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_ACCUM;
          if (iadc_valid) begin
            acc_nxt = data_ext;
            cnt_nxt = DECIM_LOG2'(1);
          end else begin
            acc_nxt = '0;
            cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, window and output registers with synchronous reset.
  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state            <= ST_IDLE;
      acc              <= '0;
      cnt              <= '0;
      odata_out        <= '0;
      onew_sample_trig <= 1'b0;
      osat_flag        <= 1'b0;
    end else begin
      state            <= state_nxt;
      acc              <= acc_nxt;
      cnt              <= cnt_nxt;
      onew_sample_trig <= emit;
      if (emit) begin
        odata_out <= sat_data;
        if (sat_ovf) begin
          osat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_sample_decimator.sv
// Self-checking bench for rx_sample_decimator (N = 8, 16-bit samples).
// A window-level reference model (list of accepted samples, pending results)
// predicts every output on every cycle; directed steps add timing checks.
module tb_rx_sample_decimator;

  localparam int LOG2 = 3;
  localparam int N    = 1 << LOG2;

  logic               crx_clk = 1'b0;
  logic               rrx_rst;
  logic               erx_en;
  logic signed [15:0] iadc_data;
  logic               iadc_valid;
  logic signed [15:0] idc_offset;
  logic signed [15:0] odata_out;
  logic               onew_sample_trig;
  logic               osat_flag;

  rx_sample_decimator #(
    .DECIM_LOG2 (LOG2),
    .IN_WIDTH   (16)
  ) dut (
    .crx_clk          (crx_clk),
    .rrx_rst          (rrx_rst),
    .erx_en           (erx_en),
    .iadc_data        (iadc_data),
    .iadc_valid       (iadc_valid),
    .idc_offset       (idc_offset),
    .odata_out        (odata_out),
    .onew_sample_trig (onew_sample_trig),
    .osat_flag        (osat_flag)
  );

  always #5 crx_clk = ~crx_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit armed = 1'b0;
  int win[$];
  typedef struct {
    int due;
    int sum;
  } pend_t;
  pend_t pend[$];
  logic signed [15:0] e_data = '0;
  logic               e_trig = 1'b0;
  logic               e_sat  = 1'b0;

  int trig_cyc[$];
  int trig_val[$];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int floor_div(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // Advances the model by one rising edge using the inputs just sampled.
  task automatic model_edge();
    int s;
    int r;
    cyc++;
    if (rrx_rst) begin
      armed = 1'b0;
      win.delete();
      pend.delete();
      e_data = '0;
      e_trig = 1'b0;
      e_sat  = 1'b0;
      return;
    end
    e_trig = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = floor_div(pend[0].sum) - int'(idc_offset);
      if (r > 32767) begin
        r = 32767;
        e_sat = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        e_sat = 1'b1;
      end
      e_data = 16'(r);
      e_trig = 1'b1;
      void'(pend.pop_front());
    end
    if (armed && erx_en && iadc_valid) begin
      win.push_back(int'(iadc_data));
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        pend.push_back('{due: cyc + 1, sum: s});
        win.delete();
      end
    end
    if (!erx_en) win.delete();
    armed = erx_en;
  endtask

  task automatic check_outputs();
    chk("trig", onew_sample_trig, e_trig);
    chk("data", odata_out, e_data);
    chk("sat", osat_flag, e_sat);
    if (onew_sample_trig === 1'b1) begin
      trig_cyc.push_back(cyc);
      trig_val.push_back(int'(odata_out));
    end
  endtask

  task automatic tick(input bit en, input bit vld, input int data);
    erx_en     = en;
    iadc_valid = vld;
    iadc_data  = 16'(data);
    @(posedge crx_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_log();
    trig_cyc.delete();
    trig_val.delete();
  endtask

  initial begin
    int v8;
    int nv;
    bit vld;
    rrx_rst    = 1'b1;
    erx_en     = 1'b0;
    iadc_valid = 1'b0;
    iadc_data  = '0;
    idc_offset = '0;

    // Reset state
    repeat (3) tick(1'b0, 1'b0, 0);
    chk("rst_data", odata_out, 0);
    chk("rst_trig", onew_sample_trig, 0);
    chk("rst_sat", osat_flag, 0);

    // Constant 100, continuous valid. A valid sampled at edge k yields a
    // trigger in the cycle after edge k+1, i.e. two cycles after the valid.
    rrx_rst = 1'b0;
    clear_log();
    tick(1'b1, 1'b0, 0);
    for (int j = 1; j <= 40; j++) begin
      tick(1'b1, 1'b1, 100);
      if (j == 8) v8 = cyc;
    end
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s1_ntrig", trig_cyc.size(), 5);
    if (trig_cyc.size() >= 5) begin
      chk("s1_first", trig_cyc[0], v8 + 1);
      for (int i = 1; i < 5; i++) begin
        chk("s1_gap", trig_cyc[i] - trig_cyc[i-1], N);
        chk("s1_val", trig_val[i], 100);
      end
    end

    // Ramp 0..7 then -1 and seven zeros: 28/8 -> 3, -1/8 floors to -1
    tick(1'b0, 1'b0, 0);
    clear_log();
    tick(1'b1, 1'b0, 0);
    for (int j = 0; j < 8; j++) tick(1'b1, 1'b1, j);
    tick(1'b1, 1'b1, -1);
    repeat (7) tick(1'b1, 1'b1, 0);
    repeat (3) tick(1'b1, 1'b0, 0);
    chk("s2_ntrig", trig_val.size(), 2);
    if (trig_val.size() >= 2) begin
      chk("s2_val0", trig_val[0], 3);
      chk("s2_val1", trig_val[1], -1);
    end
    chk("s2_sat", osat_flag, 0);

    // Negative full scale minus offset 1 clips and sets the sticky flag
    tick(1'b0, 1'b0, 0);
    idc_offset = 16'sd1;
    clear_log();
    tick(1'b1, 1'b0, 0);
    repeat (8) tick(1'b1, 1'b1, -32768);
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s3_ntrig1", trig_val.size(), 1);
    if (trig_val.size() >= 1) chk("s3_clip", trig_val[0], -32768);
    chk("s3_sat_set", osat_flag, 1);
    idc_offset = 16'sd0;
    repeat (24) tick(1'b1, 1'b1, -32768);
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s3_ntrig4", trig_val.size(), 4);
    if (trig_val.size() >= 4) chk("s3_val", trig_val[3], -32768);
    chk("s3_sat_sticky", osat_flag, 1);

    // Enable dropped after 5 valids: partial window discarded
    tick(1'b0, 1'b0, 0);
    clear_log();
    tick(1'b1, 1'b0, 0);
    repeat (5) tick(1'b1, 1'b1, $urandom_range(0, 2000));
    tick(1'b0, 1'b1, 555);
    tick(1'b1, 1'b1, 777);
    chk("s4_no_trig", trig_cyc.size(), 0);
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 1'b1, $urandom_range(0, 2000));
      if (j == 8) v8 = cyc;
    end
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s4_ntrig", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) chk("s4_when", trig_cyc[0], v8 + 1);

    // Enable dropped during the emit cycle: the trigger is still issued
    clear_log();
    repeat (8) tick(1'b1, 1'b1, $urandom_range(0, 2000));
    v8 = cyc;
    repeat (2) tick(1'b0, 1'b0, 0);
    chk("s4b_ntrig", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) chk("s4b_when", trig_cyc[0], v8 + 1);

    // One-cycle reset after 4 valids
    tick(1'b1, 1'b0, 0);
    repeat (4) tick(1'b1, 1'b1, $urandom_range(0, 2000));
    rrx_rst = 1'b1;
    tick(1'b1, 1'b1, 1234);
    rrx_rst = 1'b0;
    chk("s5_rst_data", odata_out, 0);
    chk("s5_rst_trig", onew_sample_trig, 0);
    chk("s5_rst_sat", osat_flag, 0);
    clear_log();
    tick(1'b1, 1'b0, 0);
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 1'b1, $urandom_range(0, 2000));
      if (j == 8) v8 = cyc;
    end
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s5_ntrig", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) chk("s5_when", trig_cyc[0], v8 + 1);

    // Valid every other cycle; the extra valid at i=15 lands on an emit cycle
    tick(1'b0, 1'b0, 0);
    clear_log();
    tick(1'b1, 1'b0, 0);
    nv = 0;
    for (int i = 0; i < 64; i++) begin
      vld = (i % 2 == 0) || (i == 15);
      if (vld) nv++;
      tick(1'b1, vld, $urandom_range(0, 65535));
    end
    repeat (2) tick(1'b1, 1'b0, 0);
    chk("s6_ntrig", trig_cyc.size(), nv / N);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rrx_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) idc_offset = 16'($urandom);
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, $urandom);
    end
    rrx_rst = 1'b0;
    repeat (3) tick(1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_sample_decimator.md
RX_SAMPLE_DECIMATOR -- requirements
Module: rx_sample_decimator

Interface
REQ-001 The block SHALL have parameter DECIM_LOG2, default 3, meaning decimation factor N = 2^DECIM_LOG2 (legal 1..6).
REQ-002 The block SHALL have parameter IN_WIDTH, default 16, meaning the signed ADC sample width.
REQ-003 The block SHALL have port crx_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rrx_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port erx_en, input, 1 bit: receive enable.
REQ-006 The block SHALL have port iadc_data, input, IN_WIDTH bits, signed: the raw ADC sample.
REQ-007 The block SHALL have port iadc_valid, input, 1 bit: iadc_data is valid this cycle.
REQ-008 The block SHALL have port idc_offset, input, 16 bits, signed: DC offset subtracted from each decimated sample.
REQ-009 The block SHALL have port odata_out, output, 16 bits, signed: decimated sample that feeds the sample-organizer BRAM data input.
REQ-010 The block SHALL have port onew_sample_trig, output, 1 bit: single-cycle pulse qualifying odata_out; it feeds the organizer new-sample trigger.
REQ-011 The block SHALL have port osat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-012 FSM states SHALL be IDLE, ACCUM and EMIT.
REQ-013 IDLE -> ACCUM SHALL occur when erx_en=1; in IDLE, samples are ignored.
REQ-014 In ACCUM, each cycle with iadc_valid=1 SHALL add sign-extended iadc_data to an accumulator of IN_WIDTH+DECIM_LOG2 bits and increment a DECIM_LOG2-bit counter.
REQ-015 On acceptance of the Nth sample (counter wraps to 0), the FSM SHALL move to EMIT on the next edge with the full sum registered.
REQ-016 In EMIT, result = (sum >>> DECIM_LOG2) - idc_offset SHALL be computed, with the arithmetic shift flooring toward -infinity, and the subtraction done at IN_WIDTH+1 bits.
REQ-017 The result SHALL saturate to [-32768, 32767]; any clipping SHALL set osat_flag, which stays set until reset.
REQ-018 odata_out SHALL be registered on the EMIT cycle, with onew_sample_trig=1 in the following cycle only; latency from the Nth accepted valid to the trigger SHALL be 2 cycles.
REQ-019 odata_out SHALL hold its value until the next trigger.
REQ-020 A sample with iadc_valid=1 during EMIT SHALL be accepted as sample 1 of the next window, so that no sample is lost under back-to-back valids; EMIT SHALL then return to ACCUM.
REQ-021 erx_en=0 in any state SHALL cause a transition to IDLE on the next edge, discard the partial sum, clear the counter and produce no trigger; a trigger already scheduled from EMIT SHALL still be issued.
REQ-022 The minimum trigger spacing SHALL be N cycles.

Reset
REQ-023 While rrx_rst=1, the state SHALL be IDLE and the accumulator, counter, odata_out, onew_sample_trig and osat_flag SHALL all be 0.
REQ-024 Reset mid-window SHALL discard the partial window; the first window after reset SHALL start from the first valid accepted with erx_en=1.

Structure
REQ-025 A shared rx package SHALL hold the FSM state encoding, the sample width constant (16) and the saturation limits.
REQ-026 A single sub-module, rx_saturate (signed, parameterized input width to 16-bit clip plus overflow flag), SHALL be used; all other logic SHALL be flat.

Verification
REQ-027 Bench SHALL check: N=8, offset 0, constant iadc_data=100 with continuous valid -> odata_out=100, trigger every 8 cycles, first trigger 2 cycles after the 8th valid.
REQ-028 Bench SHALL check: inputs 0..7, then -1 followed by seven 0s -> outputs 3, then -1 (floor), and osat_flag=0.
REQ-029 Bench SHALL check: constant -32768 with offset 1 -> odata_out=-32768 and osat_flag=1, still set after 3 further windows with offset 0.
REQ-030 Bench SHALL check: erx_en dropped after 5 valids, then restored -> no trigger for the partial window; the next trigger comes after 8 fresh valids.
REQ-031 Bench SHALL check: rrx_rst pulsed for 1 cycle after 4 valids -> all outputs 0 on the next cycle; the next trigger comes after 8 post-reset valids.
REQ-032 Bench SHALL check: valid asserted every other cycle, including one landing on an EMIT cycle -> sample counts per window stay exactly 8 and the sums match the reference model.
